// File: rtl/fp12_add_if.sv
// Operand/result bundle for the 12-bit float adder (s | exp[4:0] bias 15 | frac[5:0]).
// Every cycle carries a valid operand pair; there is no handshake.
interface fp12_add_if;
  logic [11:0] data_1_i;
  logic [11:0] data_2_i;
  logic [11:0] data_sum_o;

  modport master (output data_1_i, output data_2_i, input data_sum_o);
  modport slave  (input data_1_i, input data_2_i, output data_sum_o);
endinterface

// File: rtl/fp12_add_pipe.sv
// 5-stage exact adder for the 12-bit float format, result = truncated exact sum, latency 5 edges, no stalls.
// Define FP12_ADD_ROUND_EN for round-half-away-from-zero instead of truncation.
module fp12_add_pipe (
  input  logic      clk_i,
  input  logic      rst_n_i,
  fp12_add_if.slave bus
);

  // Stage 1: input register
  logic [11:0] r_a, r_b;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      r_a <= bus.data_1_i;
      r_b <= bus.data_2_i;
    end
  end

  // Stage 2: align both operands onto one 38-bit fixed-point grid (LSB = 2^-21), so the add is exact
  logic        w_zero_a, w_zero_b;
  logic [37:0] w_mag_a, w_mag_b;
  logic [37:0] r_mag_a, r_mag_b;
  logic        r_sgn_a, r_sgn_b;

  assign w_zero_a = (r_a[10:0] == 11'd0);
  assign w_zero_b = (r_b[10:0] == 11'd0);
  assign w_mag_a  = w_zero_a ? 38'd0 : ({31'd0, 1'b1, r_a[5:0]} << r_a[10:6]);
  assign w_mag_b  = w_zero_b ? 38'd0 : ({31'd0, 1'b1, r_b[5:0]} << r_b[10:6]);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_mag_a <= '0;
      r_mag_b <= '0;
      r_sgn_a <= 1'b0;
      r_sgn_b <= 1'b0;
    end else begin
      r_mag_a <= w_mag_a;
      r_mag_b <= w_mag_b;
      r_sgn_a <= r_a[11];
      r_sgn_b <= r_b[11];
    end
  end

  // Stage 3: signed-magnitude add/sub
  logic [38:0] w_sum;
  logic        w_sgn;
  logic [38:0] r_sum;
  logic        r_sgn3;

  always_comb begin
    w_sum = '0;
    w_sgn = 1'b0;
    if (r_sgn_a == r_sgn_b) begin
      w_sum = {1'b0, r_mag_a} + {1'b0, r_mag_b};
      w_sgn = r_sgn_a;
    end else if (r_mag_a >= r_mag_b) begin
      w_sum = {1'b0, r_mag_a} - {1'b0, r_mag_b};
      w_sgn = r_sgn_a;
    end else begin
      w_sum = {1'b0, r_mag_b} - {1'b0, r_mag_a};
      w_sgn = r_sgn_b;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sum  <= '0;
      r_sgn3 <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_sgn3 <= w_sgn;
    end
  end

  // Stage 4: leading-one detect and normalize so the leading one lands on bit 38
  logic [5:0]        w_lead;
  logic [38:0]       w_norm;
  logic signed [6:0] w_bexp;
  logic [5:0]        r_frac4;
  logic              r_rnd4;
  logic signed [6:0] r_bexp4;
  logic              r_zero4;
  logic              r_sgn4;

  always_comb begin
    w_lead = '0;
    for (int i = 0; i < 39; i++) begin
      if (r_sum[i]) w_lead = 6'(i);
    end
  end

  assign w_norm = r_sum << (6'd38 - w_lead);
  // Leading one at bit p weighs 2^(p-21), so the biased exponent is p-6
  assign w_bexp = $signed({1'b0, w_lead}) - 7'sd6;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_frac4 <= '0;
      r_rnd4  <= 1'b0;
      r_bexp4 <= '0;
      r_zero4 <= 1'b0;
      r_sgn4  <= 1'b0;
    end else begin
      r_frac4 <= w_norm[37:32];
      r_rnd4  <= w_norm[31];
      r_bexp4 <= w_bexp;
      r_zero4 <= (r_sum == 39'd0);
      r_sgn4  <= r_sgn3;
    end
  end

  // Stage 5: optional rounding, exponent clamp, pack
  logic signed [6:0] w_exp_r;
  logic [5:0]        w_frac_r;
  logic              w_carry;
  logic [11:0]       w_pack;
  logic              w_unused;
  logic [11:0]       r_out;

`ifdef FP12_ADD_ROUND_EN
  logic [6:0] w_frac_inc;
  assign w_frac_inc = {1'b0, r_frac4} + {6'd0, r_rnd4};
  assign w_carry    = w_frac_inc[6];
  assign w_frac_r   = w_frac_inc[5:0];
  assign w_exp_r    = r_bexp4 + $signed({6'd0, w_carry});
  assign w_unused   = ^{w_norm[38], w_norm[30:0]};
`else
  assign w_carry  = 1'b0;
  assign w_frac_r = r_frac4;
  assign w_exp_r  = r_bexp4;
  assign w_unused = ^{w_norm[38], w_norm[30:0], r_rnd4};
`endif

  always_comb begin
    w_pack = '0;
    if (!r_zero4) begin
      if (w_exp_r > 7'sd31)
        w_pack = {r_sgn4, 5'd31, (w_carry ? 6'h3F : w_frac_r)};
      else if (w_exp_r < 7'sd0)
        w_pack = {r_sgn4, 5'd0, w_frac_r};
      else
        w_pack = {r_sgn4, w_exp_r[4:0], w_frac_r};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_out <= '0;
    else          r_out <= w_pack;
  end

  assign bus.data_sum_o = r_out;

endmodule

// File: tb/tb_fp12_add_pipe.sv
// Scoreboard bench for fp12_add_pipe: directed cases, mid-stream reset, random stream vs real-arithmetic model.
module tb_fp12_add_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  typedef struct {
    logic [11:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];

  fp12_add_if u_if ();

  fp12_add_pipe u_dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (u_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%03h exp=%03h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic real dec(input logic [11:0] x);
    real v;
    if (x[10:0] == 11'd0) return 0.0;
    v = (1.0 + real'(x[5:0]) / 64.0) * (2.0 ** (real'(x[10:6]) - 15.0));
    return x[11] ? -v : v;
  endfunction

  function automatic logic [11:0] model(input logic [11:0] a, input logic [11:0] b);
    real s, mag, norm;
    int  e, f7, frac, be;
    logic sg, carry;
    s = dec(a) + dec(b);
    if (s == 0.0) return 12'h000;
    sg  = (s < 0.0);
    mag = sg ? -s : s;
    e   = -30;
    while (e < 40 && (2.0 ** (e + 1)) <= mag) e++;
    norm  = mag / (2.0 ** e);
    f7    = $rtoi((norm - 1.0) * 128.0);
    frac  = f7 >> 1;
    be    = e + 15;
    carry = 1'b0;
`ifdef FP12_ADD_ROUND_EN
    if ((f7 & 1) != 0) begin
      frac++;
      if (frac == 64) begin
        frac  = 0;
        be++;
        carry = 1'b1;
      end
    end
`endif
    if (be > 31) begin
      be = 31;
      if (carry) frac = 63;
    end else if (be < 0) begin
      be = 0;
    end
    return {sg, 5'(be), 6'(frac)};
  endfunction

  task automatic prime();
    exp_t z;
    z.val = 12'h000;
    z.tag = "lat_zero";
    repeat (4) sb.push_back(z);
  endtask

  task automatic step(input logic [11:0] a, input logic [11:0] b,
                      input logic [11:0] expv, input string tag);
    exp_t e;
    u_if.data_1_i = a;
    u_if.data_2_i = b;
    e.val = expv;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", u_if.data_sum_o, 12'hxxx);
    end else begin
      e = sb.pop_front();
      chk(e.tag, u_if.data_sum_o, e.val);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_async", u_if.data_sum_o, 12'h000);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold", u_if.data_sum_o, 12'h000);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    prime();
  endtask

  function automatic logic [11:0] rnd_op(input logic [11:0] other);
    logic [11:0] v;
    int sel;
    sel = $urandom_range(0, 9);
    v   = 12'($urandom);
    case (sel)
      0: v = {v[11], 11'd0};
      1: v = {~other[11], other[10:0]};
      2: v = {v[11], other[10:6], v[5:0]};
      3: v = {v[11], 5'(int'(other[10:6]) + $urandom_range(0, 8)), v[5:0]};
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    logic [11:0] a, b;
    u_if.data_1_i = 12'h000;
    u_if.data_2_i = 12'h000;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_init", u_if.data_sum_o, 12'h000);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_init_hold", u_if.data_sum_o, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    prime();

    step(12'h3C0, 12'h3C0, 12'h400, "basic_1p1");
    step(12'h3C0, 12'h380, 12'h3E0, "mixed_exp");
    step(12'hBC0, 12'h380, 12'hB80, "neg_mixed");
    step(12'h3E0, 12'hBE0, 12'h000, "cancel");
    step(12'h800, 12'h3C0, 12'h3C0, "negzero_a");
    step(12'h800, 12'h000, 12'h000, "negzero_both");
`ifdef FP12_ADD_ROUND_EN
    step(12'h3C1, 12'h200, 12'h3C2, "round_up");
`else
    step(12'h3C1, 12'h200, 12'h3C1, "truncate");
`endif
    step(12'h7FF, 12'h7FF, 12'h7FF, "overflow_sat");
    step(12'h041, 12'h840, 12'h000, "underflow");
    step(12'h380, 12'h3C0, 12'h3E0, "mixed_swap");

    for (int i = 0; i < 20000; i++) begin
      if (i == 5000) do_reset();
      a = 12'($urandom);
      b = rnd_op(a);
      step(a, b, model(a, b), "stream");
    end

    for (int i = 0; i < 4; i++) step(12'h000, 12'h000, 12'h000, "drain");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
